key_event_queue: RTL and testbench
==================================

KEY_EVENT_QUEUE -- requirements
Module: key_event_queue

Interface
REQ-001 Parameter NUM_KEYS, default 6: number of scancode slots per snapshot (1..16).
REQ-002 Parameter CODE_W, default 9: scancode width; code 0 = empty slot.
REQ-003 Parameter FIFO_DEPTH, default 8: event queue depth (power of two, >=2).
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 keys_in  input  NUM_KEYS*CODE_W  snapshot; slot i = bits [i*CODE_W +: CODE_W].
REQ-007 keys_valid  input  1  one-cycle strobe; keys_in valid.
REQ-008 busy  output  1  high while a snapshot is being scanned; keys_valid ignored while high.
REQ-009 evt_valid  output  1  queue head valid.
REQ-010 evt_ready  input  1  consumer accepts head when evt_valid & evt_ready.
REQ-011 evt_pressed  output  1  1 = make, 0 = break.
REQ-012 evt_code  output  CODE_W  scancode of head event.
REQ-013 fifo_level  output  $clog2(FIFO_DEPTH)+1  current queue occupancy.

Function
REQ-014 Block holds prev snapshot (NUM_KEYS slots, reset all 0) and new snapshot register.
REQ-015 FSM states: IDLE, SCAN_BREAK, SCAN_MAKE, COMMIT; slot index idx of $clog2(NUM_KEYS) bits (min 1).
REQ-016 IDLE: keys_valid=1 -> capture keys_in to new, idx<=0, go SCAN_BREAK; else stay.
REQ-017 busy = (state != IDLE).
REQ-018 SCAN_BREAK examines prev[idx]: emit break if prev[idx]!=0, no slot of new equals it, and no lower prev slot j<idx equals it (duplicate collapse).
REQ-019 SCAN_MAKE examines new[idx]: emit make if new[idx]!=0, no slot of prev equals it, and no lower new slot j<idx equals it.
REQ-020 Emit = push {pressed, code} into queue; exactly one slot examined per cycle.
REQ-021 Queue full while emit required: hold idx and state (stall), no push, no event lost; non-emitting slots advance regardless of full.
REQ-022 idx==NUM_KEYS-1 and slot done: SCAN_BREAK -> SCAN_MAKE with idx<=0; SCAN_MAKE -> COMMIT.
REQ-023 COMMIT: prev<=new, go IDLE (one cycle).
REQ-024 Unstalled scan duration = 2*NUM_KEYS+1 cycles from capture edge to IDLE.
REQ-025 Event order: all breaks (ascending prev slot), then all makes (ascending new slot).
REQ-026 Slot permutation of identical code set produces no events.
REQ-027 Queue: registered-output FIFO; pushed event visible on evt_valid the cycle after push edge.
REQ-028 Pop on evt_valid & evt_ready; simultaneous push and pop when full is not permitted (push stalls per REQ-021); simultaneous push/pop otherwise keeps fifo_level unchanged.
REQ-029 evt_pressed/evt_code hold stable while evt_valid & ~evt_ready.
REQ-030 Read/write pointers wrap modulo FIFO_DEPTH; fifo_level never exceeds FIFO_DEPTH.
REQ-031 evt_pressed/evt_code are don't-care when evt_valid=0 but shall be driven 0 after reset.

Reset
REQ-032 reset_n=0: state IDLE, idx 0, prev and new all 0, queue empty, busy 0, evt_valid 0, evt_pressed 0, evt_code 0, fifo_level 0.
REQ-033 Reset asserted mid-scan aborts scan; partial events discarded; prev returns to all 0.
REQ-034 First snapshot after reset diffs against all-zero prev.

Verification
REQ-035 Reset, keys_valid with slot0=0x04, others 0, evt_ready=1 -> single event make 0x04; busy high 13 cycles (NUM_KEYS=6).
REQ-036 prev {0x04,0x05}, snapshot {0x05,0x06} -> events in order: break 0x04, make 0x06; no event for 0x05.
REQ-037 prev {0x04,0x05}, snapshot {0x05,0x04} -> zero events; prev updated.
REQ-038 Snapshot {0x10,0x10,0,0,0,0} from empty -> exactly one make 0x10.
REQ-039 FIFO_DEPTH=2, evt_ready=0, snapshot of 4 new keys -> fifo_level 2, busy held, then evt_ready=1 drains all 4 makes in slot order with no loss.
REQ-040 Assert reset_n=0 during SCAN_MAKE -> queue empty, evt_valid 0; subsequent snapshot {0x04} yields make 0x04.

Source files
------------

// File: rtl/key_event_queue.sv
// Keyboard snapshot differ: scans old vs new scancode sets and queues
// break/make events in slot order into a small FIFO.
module key_event_queue #(
   parameter int NUM_KEYS   = 6,
   parameter int CODE_W     = 9,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [NUM_KEYS*CODE_W-1:0]  keys_in,
   input  logic                        keys_valid,
   output logic                        busy,
   output logic                        evt_valid,
   input  logic                        evt_ready,
   output logic                        evt_pressed,
   output logic [CODE_W-1:0]           evt_code,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

   localparam int IW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);

   localparam logic [1:0] IDLE       = 2'd0;
   localparam logic [1:0] SCAN_BREAK = 2'd1;
   localparam logic [1:0] SCAN_MAKE  = 2'd2;
   localparam logic [1:0] COMMIT     = 2'd3;

   localparam logic [IW-1:0] LAST = IW'(NUM_KEYS - 1);
   localparam logic [AW:0]   FULL = (AW+1)'(FIFO_DEPTH);

   logic [1:0]        state;
   logic [IW-1:0]     idx;
   logic [CODE_W-1:0] prev [NUM_KEYS];
   logic [CODE_W-1:0] cur  [NUM_KEYS];

   logic [CODE_W:0]   mem  [FIFO_DEPTH];
   logic [AW-1:0]     rd;
   logic [AW-1:0]     wr;

   logic [CODE_W-1:0] code;
   logic              hit;
   logic              dup;
   logic              scan;
   logic              emit;
   logic              full;
   logic              push;
   logic              pop;
   logic              stall;

   // Break pass looks at prev against cur; make pass swaps roles.
   always_comb begin
      code = (state == SCAN_MAKE) ? cur[idx] : prev[idx];
      hit  = 1'b0;
      dup  = 1'b0;
      for (int k = 0; k < NUM_KEYS; k++) begin
         if (((state == SCAN_MAKE) ? prev[k] : cur[k]) == code)
            hit = 1'b1;
         if ((IW'(k) < idx) &&
             (((state == SCAN_MAKE) ? cur[k] : prev[k]) == code))
            dup = 1'b1;
      end
   end

   assign scan  = (state == SCAN_BREAK) || (state == SCAN_MAKE);
   assign emit  = scan && (code != '0) && !hit && !dup;
   assign full  = (fifo_level == FULL);
   assign push  = emit && !full;
   assign stall = emit && full;
   assign pop   = evt_valid && evt_ready;

   assign busy      = (state != IDLE);
   assign evt_valid = (fifo_level != '0);
   assign {evt_pressed, evt_code} = mem[rd];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         idx   <= '0;
         for (int k = 0; k < NUM_KEYS; k++) begin
            prev[k] <= '0;
            cur[k]  <= '0;
         end
      end else begin
         unique case (state)
            IDLE: begin
               if (keys_valid) begin
                  for (int k = 0; k < NUM_KEYS; k++)
                     cur[k] <= keys_in[k*CODE_W +: CODE_W];
                  idx   <= '0;
                  state <= SCAN_BREAK;
               end
            end
            SCAN_BREAK: begin
               if (!stall) begin
                  if (idx == LAST) begin
                     idx   <= '0;
                     state <= SCAN_MAKE;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            SCAN_MAKE: begin
               if (!stall) begin
                  if (idx == LAST)
                     state <= COMMIT;
                  else
                     idx <= idx + 1'b1;
               end
            end
            COMMIT: begin
               for (int k = 0; k < NUM_KEYS; k++)
                  prev[k] <= cur[k];
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Head read straight from storage at the registered read pointer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd         <= '0;
         wr         <= '0;
         fifo_level <= '0;
         for (int k = 0; k < FIFO_DEPTH; k++)
            mem[k] <= '0;
      end else begin
         if (push) begin
            mem[wr] <= {state == SCAN_MAKE, code};
            wr      <= wr + 1'b1;
         end
         if (pop)
            rd <= rd + 1'b1;
         if (push && !pop)
            fifo_level <= fifo_level + 1'b1;
         else if (pop && !push)
            fifo_level <= fifo_level - 1'b1;
      end
   end

endmodule

// File: tb/tb_key_event_queue.sv
// Randomized + directed bench for key_event_queue against a
// set-difference reference model with an expected-event queue.
module tb_key_event_queue;

   localparam int NK = 6;
   localparam int CW = 9;
   localparam int FD = 2;

   logic                    clk = 1'b0;
   logic                    reset_n;
   logic [NK*CW-1:0]        keys_in;
   logic                    keys_valid;
   logic                    busy;
   logic                    evt_valid;
   logic                    evt_ready;
   logic                    evt_pressed;
   logic [CW-1:0]           evt_code;
   logic [$clog2(FD):0]     fifo_level;

   int n_chk  = 0;
   int n_pass = 0;
   int exp_q[$];
   int prev_m[NK];
   int mode   = 1;
   int popped = 0;
   bit held   = 1'b0;
   int last_head;

   key_event_queue #(
      .NUM_KEYS(NK), .CODE_W(CW), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .keys_in(keys_in), .keys_valid(keys_valid),
      .busy(busy), .evt_valid(evt_valid),
      .evt_ready(evt_ready), .evt_pressed(evt_pressed),
      .evt_code(evt_code), .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   function automatic bit has(input int a[NK], input int c, input int lim);
      bit r = 1'b0;
      for (int k = 0; k < lim; k++)
         if (a[k] == c) r = 1'b1;
      return r;
   endfunction

   // Events: code for a break, 512+code for a make.
   task automatic model(input int s[NK]);
      for (int i = 0; i < NK; i++)
         if (prev_m[i] != 0 && !has(s, prev_m[i], NK) &&
             !has(prev_m, prev_m[i], i))
            exp_q.push_back(prev_m[i]);
      for (int i = 0; i < NK; i++)
         if (s[i] != 0 && !has(prev_m, s[i], NK) && !has(s, s[i], i))
            exp_q.push_back(512 + s[i]);
      prev_m = s;
   endtask

   task automatic tick();
      int head;
      @(negedge clk);
      head = {evt_pressed, evt_code};
      if (held)
         check("hold", head, last_head);
      if (fifo_level > FD)
         check("level_max", int'(fifo_level), FD);
      evt_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
      if (evt_valid && evt_ready) begin
         if (exp_q.size() == 0)
            check("spurious_evt", head, -1);
         else
            check("evt", head, exp_q.pop_front());
         popped++;
      end
      held      = evt_valid && !evt_ready;
      last_head = head;
   endtask

   task automatic wait_idle(output int cyc);
      cyc = 0;
      while (busy && cyc < 500) begin
         cyc++;
         tick();
      end
      if (busy)
         check("idle_timeout", 1, 0);
   endtask

   task automatic apply(input int s[NK]);
      int n = 0;
      while (busy && n < 500) begin
         n++;
         tick();
      end
      if (busy)
         check("apply_timeout", 1, 0);
      for (int i = 0; i < NK; i++)
         keys_in[i*CW +: CW] = CW'(s[i]);
      keys_valid = 1'b1;
      model(s);
      tick();
      keys_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      mode = 1;
      while ((exp_q.size() != 0 || evt_valid || busy) && n < 300) begin
         n++;
         tick();
      end
      check({tag, "_q"}, exp_q.size(), 0);
      check({tag, "_lvl"}, int'(fifo_level), 0);
   endtask

   initial begin
      int s[NK];
      int pool[7];
      int cyc;
      int p0;
      pool = '{0, 1, 2, 3, 4, 5, 511};
      for (int i = 0; i < NK; i++) prev_m[i] = 0;
      reset_n    = 1'b0;
      keys_valid = 1'b0;
      keys_in    = '0;
      evt_ready  = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_valid", int'(evt_valid), 0);
      check("rst_code", int'(evt_code), 0);
      check("rst_pressed", int'(evt_pressed), 0);
      check("rst_level", int'(fifo_level), 0);
      reset_n = 1'b1;
      tick();

      mode = 1;
      p0 = popped;
      s = '{4, 0, 0, 0, 0, 0};
      apply(s);
      wait_idle(cyc);
      check("busy_cycles", cyc, 13);
      drain("d035");
      check("n035", popped - p0, 1);

      s = '{4, 5, 0, 0, 0, 0};
      apply(s);
      drain("d036a");
      p0 = popped;
      s = '{5, 6, 0, 0, 0, 0};
      apply(s);
      drain("d036");
      check("n036", popped - p0, 2);

      s = '{4, 5, 0, 0, 0, 0};
      apply(s);
      drain("d037a");
      p0 = popped;
      s = '{5, 4, 0, 0, 0, 0};
      apply(s);
      drain("d037");
      check("n037", popped - p0, 0);
      p0 = popped;
      s = '{0, 0, 0, 0, 0, 0};
      apply(s);
      drain("d037b");
      check("n037b", popped - p0, 2);

      p0 = popped;
      s = '{16, 16, 0, 0, 0, 0};
      apply(s);
      drain("d038");
      check("n038", popped - p0, 1);
      s = '{0, 0, 0, 0, 0, 0};
      apply(s);
      drain("d038b");

      mode = 0;
      p0 = popped;
      s = '{33, 34, 35, 36, 0, 0};
      apply(s);
      repeat (30) tick();
      check("full_level", int'(fifo_level), FD);
      check("full_busy", int'(busy), 1);
      check("full_valid", int'(evt_valid), 1);
      drain("d039");
      check("n039", popped - p0, 4);

      mode = 1;
      s = '{48, 49, 0, 0, 0, 0};
      apply(s);
      repeat (6) tick();
      check("mid_busy", int'(busy), 1);
      @(negedge clk);
      reset_n   = 1'b0;
      evt_ready = 1'b0;
      held      = 1'b0;
      exp_q.delete();
      for (int i = 0; i < NK; i++) prev_m[i] = 0;
      #1;
      check("ab_valid", int'(evt_valid), 0);
      check("ab_level", int'(fifo_level), 0);
      check("ab_busy", int'(busy), 0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      p0 = popped;
      s = '{4, 0, 0, 0, 0, 0};
      apply(s);
      drain("d040");
      check("n040", popped - p0, 1);

      for (int it = 0; it < 60; it++) begin
         mode = $urandom_range(1, 2);
         if ($urandom_range(0, 3) == 0) begin
            s = prev_m;
            for (int i = NK - 1; i > 0; i--) begin
               int j;
               int t;
               j = $urandom_range(0, i);
               t = s[i];
               s[i] = s[j];
               s[j] = t;
            end
         end else begin
            for (int i = 0; i < NK; i++)
               s[i] = pool[$urandom_range(0, 6)];
         end
         apply(s);
         if ($urandom_range(0, 1) == 1)
            wait_idle(cyc);
      end
      drain("d_rand");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
